// File: rtl/rob_read_arbiter.sv
// rob_read_arbiter: round-robin AR arbiter in front of the reorder buffer.
// Serialises upstream AR requests onto one AR port, remembers the grant
// order in a small FIFO and routes each in-order R beat back to its owner.
module rob_read_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // upstream requesters
    input  logic [4*NUM_REQ-1:0]    u_arid_i,
    input  logic [NUM_REQ-1:0]      u_arvalid_i,
    output logic [NUM_REQ-1:0]      u_arready_o,
    output logic [DATA_WIDTH-1:0]   u_rdata_o,
    output logic [3:0]              u_rid_o,
    output logic [NUM_REQ-1:0]      u_rvalid_o,
    input  logic [NUM_REQ-1:0]      u_rready_i,
    // reorder buffer slave port
    output logic [3:0]              m_arid_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [3:0]              m_rid_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    // status
    output logic [4:0]              out_cnt_o,
    output logic                    err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One order-FIFO entry: who asked, and with which ID.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [3:0]       id;
    } entry_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [3:0]         arid_q, arid_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    entry_t             mem_q [DEPTH];

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    entry_t             head;

    assign empty = (cnt_q == 5'd0);
    assign full  = (cnt_q == 5'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // Round-robin search: first valid requester above rr_ptr, wrapping.
    // NOTE: every signal written in an always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && u_arvalid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // AR FSM next-state and AR-side outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        arid_d      = arid_q;
        rr_ptr_d    = rr_ptr_q;
        push        = 1'b0;
        m_arvalid_o = 1'b0;
        u_arready_o = '0;
        unique case (state_q)
            IDLE: begin
                // registered count only: a same-cycle pop does not unblock
                if (pick_found && !full) begin
                    grant_d = pick_idx;
                    arid_d  = u_arid_i[{pick_idx, 2'b00} +: 4];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                m_arvalid_o          = 1'b1;
                u_arready_o[grant_q] = m_arready_i;
                if (m_arready_i) begin
                    push     = 1'b1;
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_arid_o = arid_q;

    // R steering from the FIFO head; data and ID always pass straight through.
    always_comb begin
        u_rvalid_o = '0;
        m_rready_o = 1'b0;
        if (!empty) begin
            u_rvalid_o[head.idx] = m_rvalid_i;
            m_rready_o           = u_rready_i[head.idx];
        end
    end

    assign u_rdata_o = m_rdata_i;
    assign u_rid_o   = m_rid_i;
    assign pop       = m_rvalid_i & m_rready_o;

    // FIFO pointers, occupancy count and sticky protocol error.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q
              | (m_rvalid_i & empty)
              | (pop & (m_rid_i != head.id));
    end

    assign out_cnt_o = cnt_q;
    assign err_o     = err_q;

    // Control state registers, all cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            arid_q   <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            arid_q   <= arid_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Order FIFO storage.
    // NOTE: the storage array has no reset; the count and pointers decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{idx: grant_q, id: arid_q};
    end

endmodule

// File: tb/tb_rob_read_arbiter.sv
// Directed bench for rob_read_arbiter (NUM_REQ=2, DEPTH=4).
module tb_rob_read_arbiter;

    localparam int DW = 8;
    localparam int NR = 2;
    localparam int DP = 4;

    logic            clk;
    logic            rst_n;
    logic [4*NR-1:0] u_arid_i;
    logic [NR-1:0]   u_arvalid_i;
    logic [NR-1:0]   u_arready_o;
    logic [DW-1:0]   u_rdata_o;
    logic [3:0]      u_rid_o;
    logic [NR-1:0]   u_rvalid_o;
    logic [NR-1:0]   u_rready_i;
    logic [3:0]      m_arid_o;
    logic            m_arvalid_o;
    logic            m_arready_i;
    logic [DW-1:0]   m_rdata_i;
    logic [3:0]      m_rid_i;
    logic            m_rvalid_i;
    logic            m_rready_o;
    logic [4:0]      out_cnt_o;
    logic            err_o;

    int n_checks = 0;
    int n_fail   = 0;

    rob_read_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .u_arid_i(u_arid_i), .u_arvalid_i(u_arvalid_i), .u_arready_o(u_arready_o),
        .u_rdata_o(u_rdata_o), .u_rid_o(u_rid_o), .u_rvalid_o(u_rvalid_o),
        .u_rready_i(u_rready_i),
        .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rvalid_i(m_rvalid_i),
        .m_rready_o(m_rready_o),
        .out_cnt_o(out_cnt_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u_arid_i    = '0;
        u_arvalid_i = '0;
        u_rready_i  = '0;
        m_arready_i = 1'b0;
        m_rdata_i   = '0;
        m_rid_i     = '0;
        m_rvalid_i  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check("rst_cnt", 32'(out_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One requester issues an AR with m_arready held high.
    task automatic issue_ar(input int idx, input logic [3:0] id, input logic [1:0] exp_rdy);
        u_arid_i[4*idx +: 4] = id;
        u_arvalid_i          = 2'(1 << idx);
        m_arready_i          = 1'b1;
        tick();
        #1;
        check("ar_valid", 32'(m_arvalid_o), 1);
        check("ar_id", 32'(m_arid_o), 32'(id));
        check("ar_ready", 32'(u_arready_o), 32'(exp_rdy));
        tick();
        u_arvalid_i = '0;
    endtask

    // One R beat with everyone ready; checks steering then the pop.
    task automatic r_beat(input logic [7:0] data, input logic [3:0] id,
                          input logic [1:0] exp_rv, input logic [4:0] exp_cnt);
        m_rvalid_i = 1'b1;
        m_rdata_i  = data;
        m_rid_i    = id;
        u_rready_i = 2'b11;
        #1;
        check("r_valid", 32'(u_rvalid_o), 32'(exp_rv));
        check("r_mready", 32'(m_rready_o), 1);
        check("r_data", 32'(u_rdata_o), 32'(data));
        check("r_id", 32'(u_rid_o), 32'(id));
        tick();
        m_rvalid_i = 1'b0;
        #1;
        check("r_cnt", 32'(out_cnt_o), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        // reset values
        check("rst_arvalid", 32'(m_arvalid_o), 0);
        check("rst_arid", 32'(m_arid_o), 0);
        check("rst_arready", 32'(u_arready_o), 0);
        check("rst_rvalid", 32'(u_rvalid_o), 0);
        check("rst_mready", 32'(m_rready_o), 0);
        check("rst_cnt0", 32'(out_cnt_o), 0);
        check("rst_err", 32'(err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single requester
        u_arid_i[3:0] = 4'h2;
        u_arvalid_i   = 2'b01;
        m_arready_i   = 1'b1;
        #1;
        check("s_arvalid_pre", 32'(m_arvalid_o), 0);
        tick();
        #1;
        check("s_arvalid", 32'(m_arvalid_o), 1);
        check("s_arid", 32'(m_arid_o), 32'h2);
        check("s_arready", 32'(u_arready_o), 32'b01);
        tick();
        u_arvalid_i = '0;
        #1;
        check("s_arready_off", 32'(u_arready_o), 0);
        check("s_arvalid_off", 32'(m_arvalid_o), 0);
        check("s_cnt1", 32'(out_cnt_o), 1);
        r_beat(8'h67, 4'h2, 2'b01, 5'd0);
        check("s_err", 32'(err_o), 0);

        // round-robin with both requesters held valid, running into full
        apply_reset();
        tick();
        u_arid_i    = {4'hf, 4'hb};
        u_arvalid_i = 2'b11;
        m_arready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("rr_arvalid", 32'(m_arvalid_o), 1);
            check("rr_arready", 32'(u_arready_o), (i % 2 == 0) ? 32'b01 : 32'b10);
            check("rr_arid", 32'(m_arid_o), (i % 2 == 0) ? 32'hb : 32'hf);
            @(posedge clk);
            #2;
            check("rr_gap", 32'(m_arvalid_o), 0);
        end
        check("full_cnt", 32'(out_cnt_o), 4);
        tick();
        #1;
        check("full_hold1", 32'(m_arvalid_o), 0);
        tick();
        #1;
        check("full_hold2", 32'(m_arvalid_o), 0);
        // one pop from head (req0, id b); grant must wait a cycle
        m_rvalid_i = 1'b1;
        m_rid_i    = 4'hb;
        m_rdata_i  = 8'h55;
        u_rready_i = 2'b11;
        #1;
        check("full_pop_rv", 32'(u_rvalid_o), 32'b01);
        tick();
        m_rvalid_i = 1'b0;
        #1;
        check("full_no_grant", 32'(m_arvalid_o), 0);
        check("full_cnt3", 32'(out_cnt_o), 3);
        tick();
        #1;
        check("full_grant", 32'(m_arvalid_o), 1);
        check("full_grant_rdy", 32'(u_arready_o), 32'b01);
        tick();
        u_arvalid_i = '0;
        #1;
        check("full_cnt4", 32'(out_cnt_o), 4);

        // ID mismatch on handshake: head is req1 id f, return id 3
        m_rvalid_i = 1'b1;
        m_rid_i    = 4'h3;
        #1;
        check("mm_rv", 32'(u_rvalid_o), 32'b10);
        check("mm_err_pre", 32'(err_o), 0);
        tick();
        m_rvalid_i = 1'b0;
        #1;
        check("mm_err", 32'(err_o), 1);
        check("mm_cnt", 32'(out_cnt_o), 3);
        tick();
        check("mm_err_hold", 32'(err_o), 1);

        // R valid with the FIFO empty
        apply_reset();
        check("e_err_rst", 32'(err_o), 0);
        m_rvalid_i = 1'b1;
        u_rready_i = 2'b11;
        #1;
        check("e_rvalid", 32'(u_rvalid_o), 0);
        check("e_mready", 32'(m_rready_o), 0);
        tick();
        m_rvalid_i = 1'b0;
        #1;
        check("e_err", 32'(err_o), 1);
        tick();
        check("e_err_hold", 32'(err_o), 1);

        // routing with upstream backpressure
        apply_reset();
        issue_ar(0, 4'hb, 2'b01);
        issue_ar(1, 4'hf, 2'b10);
        issue_ar(0, 4'he, 2'b01);
        #1;
        check("rt_cnt3", 32'(out_cnt_o), 3);
        r_beat(8'h1a, 4'hb, 2'b01, 5'd2);
        m_rvalid_i = 1'b1;
        m_rdata_i  = 8'h99;
        m_rid_i    = 4'hf;
        u_rready_i = 2'b01;
        #1;
        check("rt_bp_rv", 32'(u_rvalid_o), 32'b10);
        check("rt_bp_mready", 32'(m_rready_o), 0);
        tick();
        check("rt_bp_cnt", 32'(out_cnt_o), 2);
        r_beat(8'h99, 4'hf, 2'b10, 5'd1);
        r_beat(8'hee, 4'he, 2'b01, 5'd0);
        check("rt_err", 32'(err_o), 0);

        // reset with 3 outstanding and an AR pending
        apply_reset();
        issue_ar(0, 4'h1, 2'b01);
        issue_ar(1, 4'h2, 2'b10);
        issue_ar(0, 4'h3, 2'b01);
        u_arid_i    = {4'h5, 4'h4};
        u_arvalid_i = 2'b10;
        m_arready_i = 1'b0;
        tick();
        #1;
        check("mr_arvalid", 32'(m_arvalid_o), 1);
        check("mr_cnt", 32'(out_cnt_o), 3);
        m_rvalid_i = 1'b1;
        u_rready_i = 2'b11;
        rst_n      = 1'b0;
        #1;
        check("mr_rst_arvalid", 32'(m_arvalid_o), 0);
        check("mr_rst_arid", 32'(m_arid_o), 0);
        check("mr_rst_cnt", 32'(out_cnt_o), 0);
        check("mr_rst_rvalid", 32'(u_rvalid_o), 0);
        check("mr_rst_mready", 32'(m_rready_o), 0);
        check("mr_rst_err", 32'(err_o), 0);
        m_rvalid_i  = 1'b0;
        u_arvalid_i = 2'b11;
        m_arready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        check("mr_first_grant", 32'(u_arready_o), 32'b01);
        check("mr_first_id", 32'(m_arid_o), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
